// File: rtl/fpga_rst_seq.sv
// Reset sequencer downstream of the PLL: lock -> IDELAYCTRL reset pulse -> ready -> core -> camera.
// Define FPGA_RST_SEQ_WDOG_EN to build the IDELAYCTRL ready watchdog, its retry counter and the FAULT state.
module fpga_rst_seq #(
  parameter int SYNC_STAGES  = 3,
  parameter int IDLY_RST_CYC = 16,
  parameter int STAGE_GAP    = 256,
  parameter int RDY_TIMEOUT  = 65535,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       pll_lock_a,
  input  logic       idly_rdy_a,
  output logic       idly_rst,
  output logic       rst_core_n,
  output logic       rst_cam_n,
  output logic       seq_done,
  output logic       seq_fault,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    IDLY_RST,
    IDLY_WAIT,
    CORE_REL,
    RUN
`ifdef FPGA_RST_SEQ_WDOG_EN
    , FAULT
`endif
  } state_t;

  localparam logic [15:0] IDLY_LD = 16'(IDLY_RST_CYC - 1);
  localparam logic [15:0] GAP_LD  = 16'(STAGE_GAP - 1);
  localparam logic [15:0] TMO_LD  = 16'(RDY_TIMEOUT);

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic                   lock_s;
  logic                   rdy_s;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        idly_rst_nxt, rst_core_n_nxt, rst_cam_n_nxt, seq_done_nxt;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      lock_sync <= '0;
      rdy_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock_a};
      rdy_sync  <= {rdy_sync[SYNC_STAGES-2:0], idly_rdy_a};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign rdy_s  = rdy_sync[SYNC_STAGES-1];

`ifdef FPGA_RST_SEQ_WDOG_EN
  logic [3:0] retry_q, retry_nxt, retry_inc;
  logic       seq_fault_nxt;

  assign retry_inc = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef FPGA_RST_SEQ_WDOG_EN
    retry_nxt = retry_q;
`endif
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = IDLY_RST;
          cnt_nxt   = IDLY_LD;
        end
      end
      IDLY_RST: begin
        if (cnt == '0) begin
          state_nxt = IDLY_WAIT;
          cnt_nxt   = TMO_LD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      IDLY_WAIT: begin
        if (rdy_s) begin
          state_nxt = CORE_REL;
          cnt_nxt   = GAP_LD;
        end
`ifdef FPGA_RST_SEQ_WDOG_EN
        else if (cnt == '0) begin
          retry_nxt = retry_inc;
          cnt_nxt   = IDLY_LD;
          state_nxt = (retry_inc == 4'(MAX_RETRY)) ? FAULT : IDLY_RST;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
`endif
      end
      CORE_REL: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 16'd1;
      end
      RUN: ;
`ifdef FPGA_RST_SEQ_WDOG_EN
      FAULT: ;
`endif
      default: state_nxt = WAIT_LOCK;
    endcase

    // Global overrides: ready loss restarts the IDELAYCTRL pulse, lock loss beats everything.
    if ((state == CORE_REL || state == RUN) && !rdy_s) begin
      state_nxt = IDLY_RST;
      cnt_nxt   = IDLY_LD;
    end
    if (state != WAIT_LOCK && !lock_s) state_nxt = WAIT_LOCK;
`ifdef FPGA_RST_SEQ_WDOG_EN
    if (state_nxt == WAIT_LOCK) retry_nxt = 4'd0;
`endif

    idly_rst_nxt   = 1'b0;
    rst_core_n_nxt = 1'b0;
    rst_cam_n_nxt  = 1'b0;
    seq_done_nxt   = 1'b0;
`ifdef FPGA_RST_SEQ_WDOG_EN
    seq_fault_nxt  = 1'b0;
`endif
    case (state_nxt)
      WAIT_LOCK, IDLY_RST: idly_rst_nxt = 1'b1;
      CORE_REL:            rst_core_n_nxt = 1'b1;
      RUN: begin
        rst_core_n_nxt = 1'b1;
        rst_cam_n_nxt  = 1'b1;
        seq_done_nxt   = 1'b1;
      end
`ifdef FPGA_RST_SEQ_WDOG_EN
      FAULT: begin
        idly_rst_nxt  = 1'b1;
        seq_fault_nxt = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Outputs are registered from the next-state decode so they move with the state register.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      idly_rst   <= 1'b1;
      rst_core_n <= 1'b0;
      rst_cam_n  <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idly_rst   <= idly_rst_nxt;
      rst_core_n <= rst_core_n_nxt;
      rst_cam_n  <= rst_cam_n_nxt;
      seq_done   <= seq_done_nxt;
    end
  end

`ifdef FPGA_RST_SEQ_WDOG_EN
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      retry_q   <= 4'd0;
      seq_fault <= 1'b0;
    end else begin
      retry_q   <= retry_nxt;
      seq_fault <= seq_fault_nxt;
    end
  end

  assign retry_cnt = retry_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^4'(MAX_RETRY);
  assign retry_cnt  = 4'd0;
  assign seq_fault  = 1'b0;
`endif

endmodule
